// File: rtl/vga_sprite_multi_core.sv
// Multi-sprite overlay for the VGA stream: N_SPR 2-bpp animated sprites, fixed priority, 2-cycle
// latency. Define SPRITE_COLLISION_EN to build sticky sprite-to-sprite collision status.
module vga_sprite_multi_core #(
  parameter int unsigned CD       = 12,
  parameter int unsigned N_SPR    = 4,
  parameter int unsigned SPR_W    = 32,
  parameter int unsigned SPR_H    = 32,
  parameter int unsigned FRAMES   = 4,
  parameter logic [1:0]  KEY_CODE = 2'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [15:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int unsigned Depth = SPR_W * SPR_H * FRAMES;
  localparam int unsigned RA    = $clog2(Depth);

  logic                      origin_q;
  logic                      frame_start;
  logic                      reg_wr, ram_wr, glob_wr, stat_rd;
  logic                      bypass_q;
  logic [CD-1:0]             si_q, so_q, pix;
  logic [31:0]               rd_q;
  logic [N_SPR-1:0]          vis;
  logic [N_SPR-1:0][CD-1:0]  pal_vis;
  logic [N_SPR-1:0]          coll_q;
  logic                      unused_bus;

  assign frame_start = (x == 11'd0) && (y == 11'd0) && !origin_q;
  assign reg_wr      = cs & write & addr[15] & ~addr[6];
  assign ram_wr      = cs & write & ~addr[15];
  assign glob_wr     = cs & write & addr[15] & addr[6] & ~addr[0];
  assign stat_rd     = cs & read & addr[15] & addr[6] & addr[0];
  assign unused_bus  = ^{wr_data, addr};

  for (genvar s = 0; s < N_SPR; s++) begin : g_spr
    logic [10:0]   x0_q, y0_q;
    logic          en_q, anim_q;
    logic [1:0]    frame_q;
    logic [7:0]    period_q, cnt_q;
    logic [CD-1:0] pal_q [3];
    logic [1:0]    mem [Depth];
    logic [1:0]    code_q;
    logic          hit_q;
    logic          sel, ctrl_wr, hit, wrap;
    logic [RA-1:0] ra;

    assign sel     = (addr[5:3] == 3'(s));
    assign ctrl_wr = reg_wr & sel & (addr[2:0] == 3'd2);
    // 12-bit compare so a sprite near column/row 2047 does not wrap to 0
    assign hit = ({1'b0, x} >= {1'b0, x0_q}) && ({1'b0, x} < {1'b0, x0_q} + 12'(SPR_W)) &&
                 ({1'b0, y} >= {1'b0, y0_q}) && ({1'b0, y} < {1'b0, y0_q} + 12'(SPR_H));
    assign ra  = RA'(frame_q) * RA'(SPR_W * SPR_H) + RA'(y - y0_q) * RA'(SPR_W) +
                 RA'(x - x0_q);
    assign wrap = cnt_q >= ((period_q == 8'd0) ? 8'd0 : period_q - 8'd1);

    always_ff @(posedge clk) begin
      if (reset) begin
        x0_q     <= '0;
        y0_q     <= '0;
        en_q     <= 1'b0;
        anim_q   <= 1'b0;
        frame_q  <= '0;
        period_q <= '0;
        cnt_q    <= '0;
        hit_q    <= 1'b0;
        for (int i = 0; i < 3; i++) pal_q[i] <= '0;
      end else begin
        hit_q <= hit;
        if (!ctrl_wr && frame_start && anim_q) begin
          if (wrap) begin
            cnt_q   <= '0;
            frame_q <= (frame_q + 2'd1) & 2'(FRAMES - 1);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        if (reg_wr && sel) begin
          case (addr[2:0])
            3'd0: x0_q <= wr_data[10:0];
            3'd1: y0_q <= wr_data[10:0];
            3'd2: begin
              en_q    <= wr_data[3];
              anim_q  <= wr_data[2];
              frame_q <= wr_data[1:0] & 2'(FRAMES - 1);
              cnt_q   <= '0;
            end
            3'd3: period_q <= wr_data[7:0];
            3'd4: pal_q[0] <= wr_data[CD-1:0];
            3'd5: pal_q[1] <= wr_data[CD-1:0];
            3'd6: pal_q[2] <= wr_data[CD-1:0];
            default: ;
          endcase
        end
      end
    end

    // Read-first: a same-edge write leaves code_q with the old word
    always_ff @(posedge clk) begin
      if (ram_wr && (addr[RA+2:RA] == 3'(s))) mem[addr[RA-1:0]] <= wr_data[1:0];
      code_q <= mem[ra];
    end

    assign vis[s]     = en_q & hit_q & (code_q != KEY_CODE);
    assign pal_vis[s] = (code_q == 2'd1) ? pal_q[0] :
                        (code_q == 2'd2) ? pal_q[1] :
                        (code_q == 2'd3) ? pal_q[2] : '0;
  end

  always_comb begin
    pix = si_q;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (vis[i]) pix = pal_vis[i];
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [3:0] nvis;
  always_comb begin
    nvis = '0;
    for (int i = 0; i < N_SPR; i++) nvis = nvis + 4'(vis[i]);
  end

  // Read clears only the old bits; a detection on the same edge still lands
  always_ff @(posedge clk) begin
    if (reset) coll_q <= '0;
    else       coll_q <= (stat_rd ? '0 : coll_q) | ((nvis >= 4'd2) ? vis : '0);
  end
`else
  assign coll_q = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      origin_q <= 1'b0;
      bypass_q <= 1'b0;
      si_q     <= '0;
      so_q     <= '0;
      rd_q     <= '0;
    end else begin
      origin_q <= (x == 11'd0) && (y == 11'd0);
      si_q     <= si_rgb;
      so_q     <= bypass_q ? si_q : pix;
      rd_q     <= stat_rd ? 32'(coll_q) : '0;
      if (glob_wr) bypass_q <= wr_data[0];
    end
  end

  assign so_rgb  = so_q;
  assign rd_data = rd_q;

endmodule

// File: tb/tb_vga_sprite_multi_core.sv
// Directed bench for vga_sprite_multi_core; collision expectations follow SPRITE_COLLISION_EN.
module tb_vga_sprite_multi_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        cs, write, read;
  logic [15:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [11:0] si_rgb, so_rgb;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd;

`ifdef SPRITE_COLLISION_EN
  localparam logic [31:0] Coll03 = 32'h3;
  localparam logic [31:0] Coll05 = 32'h5;
`else
  localparam logic [31:0] Coll03 = 32'h0;
  localparam logic [31:0] Coll05 = 32'h0;
`endif

  vga_sprite_multi_core dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .read    (read),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    tick();
    cs = 1'b0; read = 1'b0;
    d = rd_data;
  endtask

  function automatic logic [15:0] reg_a(input int s, input int r);
    return 16'(32'h8000 + s * 8 + r);
  endfunction

  task automatic set_pix(input int px, input int py, input logic [11:0] si);
    x = 11'(px); y = 11'(py); si_rgb = si;
  endtask

  task automatic probe(input string tag, input int px, input int py, input logic [11:0] si,
                       input logic [11:0] exp);
    set_pix(px, py, si);
    tick();
    tick();
    chk(tag, 32'(so_rgb), 32'(exp));
  endtask

  task automatic frame_pulse();
    set_pix(0, 0, 12'h777);
    tick();
    set_pix(5, 5, 12'h777);
    tick();
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0; wr_data = '0;
    set_pix(5, 5, 12'hABC);
    tick(); tick();
    reset = 1'b0;
    chk("reset_so_rgb", 32'(so_rgb), 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);

    // Sprites 0..2 frame 0 all code 1; one key pixel in sprite 0 at (5,1)
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 1024; i++) bus_wr(16'((s << 12) + i), 32'd1);
    bus_wr(16'(32 + 5), 32'd0);
    // Sprite 3 pixel (0,0): frame f -> code 1,2,3,0
    bus_wr(16'((3 << 12) + 0),    32'd1);
    bus_wr(16'((3 << 12) + 1024), 32'd2);
    bus_wr(16'((3 << 12) + 2048), 32'd3);
    bus_wr(16'((3 << 12) + 3072), 32'd0);

    bus_wr(reg_a(0, 4), 32'hF00);
    bus_wr(reg_a(0, 0), 32'd100);
    bus_wr(reg_a(0, 1), 32'd50);
    bus_wr(reg_a(0, 2), 32'h8);
    for (int px = 99; px <= 132; px++)
      probe("sweep", px, 50, 12'h123, (px >= 100 && px <= 131) ? 12'hF00 : 12'h123);
    probe("key_pixel", 105, 51, 12'h123, 12'h123);
    probe("next_to_key", 104, 51, 12'h123, 12'hF00);

    // Overlap sprites 0/1 at (200,200)
    bus_wr(reg_a(1, 4), 32'h0F0);
    bus_wr(reg_a(1, 0), 32'd190);
    bus_wr(reg_a(1, 1), 32'd190);
    bus_wr(reg_a(1, 2), 32'h8);
    bus_wr(reg_a(0, 4), 32'h00F);
    bus_wr(reg_a(0, 0), 32'd195);
    bus_wr(reg_a(0, 1), 32'd195);
    probe("prio_idx0", 200, 200, 12'h321, 12'h00F);
    bus_wr(reg_a(0, 2), 32'h0);
    probe("prio_idx1", 200, 200, 12'h321, 12'h0F0);
    bus_wr(16'h8040, 32'h1);
    probe("bypass", 200, 200, 12'h456, 12'h456);
    bus_wr(16'h8040, 32'h0);
    probe("bypass_off", 200, 200, 12'h456, 12'h0F0);
    bus_rd(16'h8041, rd);
    chk("coll_0_1", rd, Coll03);

    // Overlap sprites 0/2
    bus_wr(reg_a(1, 2), 32'h0);
    bus_wr(reg_a(2, 4), 32'hAAA);
    bus_wr(reg_a(2, 0), 32'd195);
    bus_wr(reg_a(2, 1), 32'd195);
    bus_wr(reg_a(2, 2), 32'h8);
    bus_wr(reg_a(0, 2), 32'h8);
    probe("prio_0_over_2", 200, 200, 12'h321, 12'h00F);
    set_pix(5, 5, 12'h321);
    tick(); tick();
    bus_rd(16'h8041, rd);
    chk("coll_0_2", rd, Coll05);
    bus_rd(16'h8041, rd);
    chk("coll_cleared", rd, 32'h0);
    // Detection lands on the same edge as the clearing read
    set_pix(200, 200, 12'h321);
    tick();
    set_pix(5, 5, 12'h321);
    bus_rd(16'h8041, rd);
    chk("coll_read_same_edge", rd, 32'h0);
    bus_rd(16'h8041, rd);
    chk("coll_kept", rd, Coll05);
    bus_rd(16'h8041, rd);
    chk("coll_cleared2", rd, 32'h0);

    // No horizontal wrap near column 2047
    bus_wr(reg_a(0, 0), 32'd2040);
    bus_wr(reg_a(0, 1), 32'd300);
    probe("edge_2047", 2047, 300, 12'h555, 12'h00F);
    probe("edge_nowrap", 0, 300, 12'h555, 12'h555);

    // Animation on sprite 3
    bus_wr(reg_a(3, 4), 32'h111);
    bus_wr(reg_a(3, 5), 32'h222);
    bus_wr(reg_a(3, 6), 32'h333);
    bus_wr(reg_a(3, 0), 32'd600);
    bus_wr(reg_a(3, 1), 32'd400);
    bus_wr(reg_a(3, 3), 32'd3);
    bus_wr(reg_a(3, 2), 32'hC);
    probe("anim_f0", 600, 400, 12'h777, 12'h111);
    frame_pulse(); frame_pulse();
    probe("anim_2_pulses", 600, 400, 12'h777, 12'h111);
    frame_pulse();
    probe("anim_3_pulses", 600, 400, 12'h777, 12'h222);
    for (int i = 0; i < 6; i++) frame_pulse();
    probe("anim_9_pulses", 600, 400, 12'h777, 12'h777);
    for (int i = 0; i < 3; i++) frame_pulse();
    probe("anim_wrap_12", 600, 400, 12'h777, 12'h111);
    bus_wr(reg_a(3, 3), 32'd0);
    frame_pulse();
    probe("period0_f1", 600, 400, 12'h777, 12'h222);
    frame_pulse();
    probe("period0_f2", 600, 400, 12'h777, 12'h333);
    // ctrl write on the advance edge wins
    set_pix(0, 0, 12'h777);
    cs = 1'b1; write = 1'b1; addr = reg_a(3, 2); wr_data = 32'hC;
    tick();
    cs = 1'b0; write = 1'b0;
    set_pix(5, 5, 12'h777);
    tick();
    probe("ctrl_wins", 600, 400, 12'h777, 12'h111);
    bus_wr(reg_a(3, 2), 32'h9);
    probe("freeze_f1", 600, 400, 12'h777, 12'h222);
    frame_pulse();
    probe("freeze_hold", 600, 400, 12'h777, 12'h222);

    // Mid-line reset
    set_pix(600, 400, 12'h777);
    reset = 1'b1;
    tick();
    chk("midreset_so_rgb", 32'(so_rgb), 32'h0);
    reset = 1'b0;
    probe("after_reset_disabled", 600, 400, 12'h777, 12'h777);
    bus_rd(16'h8041, rd);
    chk("after_reset_coll", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
